// File: rtl/cost_table_loader.sv
// ----------------------------------------------------------------------------
// cost_table_loader
//
// Loads a 64-entry (8 workers x 8 jobs) cost table from a valid/ready stream,
// then holds the assignment engine in reset for one ARM cycle, releases it in
// RUN while serving zero-latency cost lookups, and parks in DONE until a
// reload is requested.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   in_valid/ready  load-stream handshake
//   in_data         cost entry, worker-major / job-minor raster order
//   in_last         marks the 64th entry of the stream
//   W, J            lookup indices from the assignment engine
//   Cost            mem[{W,J}] in RUN, else 0 (combinational)
//   Valid           engine completion flag (honoured only in RUN)
//   jam_rst         reset to the engine (high in LOAD and ARM)
//   reload          start a new load (honoured only in DONE)
//   done            high only in DONE
//   err             sticky framing error, cleared only by RST
//   checksum        sum of the 64 accepted entries (0 while loading)
// ----------------------------------------------------------------------------
module cost_table_loader #(
    parameter int COST_W = 7,
    parameter int N      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_last,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    output logic              jam_rst,
    input  logic              reload,
    output logic              done,
    output logic              err,
    output logic [12:0]       checksum
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int ENTRIES = N * N;

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [12:0]       acc_q, acc_d;
    logic              err_q, err_d;
    logic              accept;
    logic [12:0]       acc_inc;

    logic [COST_W-1:0] mem [0:ENTRIES-1];

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign acc_inc  = acc_q + {6'd0, in_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (cnt_q == 6'd63) begin
                        // Full table: a missing in_last is flagged but the
                        // table is still considered complete.
                        state_d = S_ARM;
                        cnt_d   = 6'd0;
                        acc_d   = acc_inc;
                        if (!in_last)
                            err_d = 1'b1;
                    end else if (in_last) begin
                        // Short frame: restart the table from entry 0.
                        cnt_d = 6'd0;
                        acc_d = 13'd0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        acc_d = acc_inc;
                    end
                end
            end
            S_ARM:  state_d = S_RUN;
            S_RUN:  if (Valid) state_d = S_DONE;
            S_DONE: begin
                if (reload) begin
                    state_d = S_LOAD;
                    cnt_d   = 6'd0;
                    acc_d   = 13'd0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_LOAD;
            cnt_q   <= 6'd0;
            acc_q   <= 13'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Table storage is not reset; Cost masks it outside RUN. A short frame
    // still writes its entries, which are overwritten by the restarted load.
    always_ff @(posedge CLK) begin
        if (!RST && accept)
            mem[cnt_q] <= in_data;
    end

    assign Cost     = (state_q == S_RUN) ? mem[{W, J}] : '0;
    assign jam_rst  = (state_q == S_LOAD) || (state_q == S_ARM);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign checksum = (state_q == S_LOAD) ? 13'd0 : acc_q;

endmodule

// File: tb/tb_cost_table_loader.sv
module tb_cost_table_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic        jam_rst;
    logic        reload = 1'b0;
    logic        done;
    logic        err;
    logic [12:0] checksum;

    int checks = 0;
    int failures = 0;

    cost_table_loader #(.COST_W(7), .N(8)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .W(W), .J(J), .Cost(Cost), .Valid(Valid),
        .jam_rst(jam_rst), .reload(reload), .done(done), .err(err),
        .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] entry(input int mode, input int i);
        case (mode)
            0:       return 7'(i);
            1:       return 7'(63 - i);
            default: return 7'd127;
        endcase
    endfunction

    // Streams n entries; in_last on index last_at. With gap set, in_valid
    // drops for a cycle after each entry and Valid is pulsed meanwhile.
    task automatic load(input int mode, input bit gap, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = entry(mode, i);
            in_last  = (i == last_at);
            step();
            if (i == 62 && n == 64)
                chk("ready_before_last", int'(in_ready), 1);
            if (gap) begin
                in_valid = 1'b0;
                Valid    = 1'b1;
                step();
                Valid    = 1'b0;
                if (i < 63)
                    chk("ready_gap", int'(in_ready), 1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_run();
        Valid = 1'b1; step(); Valid = 1'b0;
        chk("done_set", int'(done), 1);
        chk("cost_done", int'(Cost), 0);
        chk("jam_done", int'(jam_rst), 0);
        reload = 1'b1; step(); reload = 1'b0;
        chk("reload_ready", int'(in_ready), 1);
        chk("reload_jam", int'(jam_rst), 1);
        chk("reload_csum", int'(checksum), 0);
        chk("reload_done", int'(done), 0);
    endtask

    initial begin
        // Reset state
        RST = 1'b1; step(); RST = 1'b0;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_jam", int'(jam_rst), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_cost", int'(Cost), 0);
        chk("rst_csum", int'(checksum), 0);
        chk("rst_err", int'(err), 0);

        // Continuous load of i; ARM after last accept
        load(0, 1'b0, 64, 63);
        chk("arm_ready", int'(in_ready), 0);
        chk("arm_jam", int'(jam_rst), 1);
        chk("arm_csum", int'(checksum), 2016);
        chk("arm_cost", int'(Cost), 0);
        step();
        chk("run_jam", int'(jam_rst), 0);
        chk("run_err", int'(err), 0);
        W = 3'd3; J = 3'd5; #1;
        chk("cost_3_5", int'(Cost), 29);
        W = 3'd7; J = 3'd7; #1;
        chk("cost_7_7", int'(Cost), 63);
        // reload ignored in RUN
        reload = 1'b1; step(); reload = 1'b0;
        chk("run_reload_ign_done", int'(done), 0);
        chk("run_reload_ign_jam", int'(jam_rst), 0);
        chk("run_csum", int'(checksum), 2016);
        finish_run();

        // Gapped load with Valid pulsed during LOAD
        load(0, 1'b1, 64, 63);
        chk("gap_csum", int'(checksum), 2016);
        step();
        W = 3'd0; J = 3'd0; #1;
        chk("gap_cost_0_0", int'(Cost), 0);
        W = 3'd5; J = 3'd2; #1;
        chk("gap_cost_5_2", int'(Cost), 42);
        W = 3'd7; J = 3'd7; #1;
        chk("gap_cost_7_7", int'(Cost), 63);
        finish_run();

        // Early in_last on entry 10, then full reload of 63-i
        load(0, 1'b0, 11, 10);
        chk("short_err", int'(err), 1);
        chk("short_ready", int'(in_ready), 1);
        chk("short_csum", int'(checksum), 0);
        load(1, 1'b0, 64, 63);
        chk("relo_csum", int'(checksum), 2016);
        step();
        chk("relo_jam", int'(jam_rst), 0);
        chk("relo_err", int'(err), 1);
        W = 3'd0; J = 3'd0; #1;
        chk("relo_cost_0_0", int'(Cost), 63);
        W = 3'd3; J = 3'd5; #1;
        chk("relo_cost_3_5", int'(Cost), 34);
        finish_run();
        chk("err_sticky_reload", int'(err), 1);

        // Reset mid-load, then all-127 load
        load(0, 1'b0, 31, -1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_err", int'(err), 0);
        chk("midrst_csum", int'(checksum), 0);
        load(2, 1'b0, 64, 63);
        chk("max_csum", int'(checksum), 8128);
        step();
        W = 3'd6; J = 3'd1; #1;
        chk("max_cost", int'(Cost), 127);
        chk("max_err", int'(err), 0);
        // Reset from RUN
        RST = 1'b1; Valid = 1'b1; step(); RST = 1'b0; Valid = 1'b0;
        chk("runrst_ready", int'(in_ready), 1);
        chk("runrst_cost", int'(Cost), 0);
        chk("runrst_done", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
